// File: rtl/scrambler_par.sv
// Additive LFSR scrambler/descrambler, DATA_W bits per beat; header beats bypass the keystream.
// Latency: 1 clk from input to output on every beat.
// Backpressure: none; the output never stalls. Optional `SCR_STATS_EN adds frame statistics outputs.
module scrambler_par #(
    parameter int                DATA_W  = 1,
    parameter int                LFSR_W  = 8,
    parameter logic [LFSR_W-1:0] TAPS    = 8'h95,
    parameter logic [LFSR_W-1:0] SEED    = 8'hAA,
    parameter logic [7:0]        HDR_LEN = 8'd7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_en,
    input  logic [7:0]        cfg_hdr_len,
    input  logic              i_valid,
    input  logic              i_last,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    output logic              o_last,
    output logic [DATA_W-1:0] o_data
`ifdef SCR_STATS_EN
    ,
    output logic [15:0]       o_frame_cnt,
    output logic              o_short_frame
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t              state;
    logic [7:0]          beat_cnt;
    logic [7:0]          hdr_len_q;
    logic [LFSR_W-1:0]   lfsr;

    logic [DATA_W-1:0]   keystream;
    logic [LFSR_W-1:0]   lfsr_adv;
    logic [7:0]          beat_cnt_inc;
    logic                payload_beat;
    logic                frame_end;

    // Unroll DATA_W LFSR steps: bit i of the keystream pairs with data bit i (earliest first).
    always_comb begin : ks_gen
        logic [LFSR_W-1:0] s;
        s         = lfsr;
        keystream = '0;
        for (int i = 0; i < DATA_W; i++) begin
            keystream[i] = s[LFSR_W-1];
            s            = {s[LFSR_W-2:0], ^(s & TAPS)};
        end
        lfsr_adv = s;
    end

    // beat_cnt saturates so very long frames never alias back into the header.
    assign beat_cnt_inc = (beat_cnt == 8'hFF) ? beat_cnt : beat_cnt + 8'd1;

    // A zero-length header makes the very first beat (still seen in IDLE) a payload beat.
    assign payload_beat = i_valid &&
                          ((state == DATA) || ((state == IDLE) && (hdr_len_q == 8'd0)));

    assign frame_end = i_valid & i_last;

    // Frame tracking FSM, LFSR and registered datapath.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            beat_cnt  <= 8'd0;
            hdr_len_q <= HDR_LEN;
            lfsr      <= SEED;
            o_valid   <= 1'b0;
            o_last    <= 1'b0;
            o_data    <= '0;
        end else begin
            o_valid <= i_valid;
            o_last  <= frame_end;
            // The LFSR advances on payload beats even in bypass so cfg_en can toggle mid-frame.
            o_data  <= (payload_beat && cfg_en) ? (i_data ^ keystream) : i_data;

            if (state == IDLE) begin
                hdr_len_q <= cfg_hdr_len;
            end

            if (!i_valid || i_last) begin
                // A gap or an accepted last beat closes the frame and reseeds.
                state    <= IDLE;
                lfsr     <= SEED;
                beat_cnt <= 8'd0;
            end else begin
                case (state)
                    IDLE: begin
                        beat_cnt <= 8'd1;
                        state    <= (hdr_len_q > 8'd1) ? HDR : DATA;
                        if (payload_beat) begin
                            lfsr <= lfsr_adv;
                        end
                    end
                    HDR: begin
                        beat_cnt <= beat_cnt_inc;
                        if (beat_cnt_inc == hdr_len_q) begin
                            state <= DATA;
                        end
                    end
                    DATA: begin
                        beat_cnt <= beat_cnt_inc;
                        lfsr     <= lfsr_adv;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

`ifdef SCR_STATS_EN
    logic hdr_short;

    // Frame ended before its header completed (single beat with a multi-beat header, or early in HDR).
    assign hdr_short = frame_end &&
                       (((state == IDLE) && (hdr_len_q > 8'd1)) ||
                        ((state == HDR) && (beat_cnt_inc < hdr_len_q)));

    // Frame counter and short-frame pulse, both registered alongside the data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_frame_cnt   <= 16'd0;
            o_short_frame <= 1'b0;
        end else begin
            o_short_frame <= hdr_short;
            if (frame_end) begin
                o_frame_cnt <= o_frame_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_scrambler_par.sv
// Randomized self-checking bench for scrambler_par (DATA_W=4, default LFSR/header settings).
// Reference model works on frame positions and a precomputed serial keystream.
module tb_scrambler_par;
    localparam int DW = 4;

    logic          clk;
    logic          rst;
    logic          cfg_en;
    logic [7:0]    cfg_hdr_len;
    logic          i_valid;
    logic          i_last;
    logic [DW-1:0] i_data;
    logic          o_valid;
    logic          o_last;
    logic [DW-1:0] o_data;
`ifdef SCR_STATS_EN
    logic [15:0]   o_frame_cnt;
    logic          o_short_frame;
    int            short_seen;
`endif

    scrambler_par #(
        .DATA_W (DW),
        .LFSR_W (8),
        .TAPS   (8'h95),
        .SEED   (8'hAA),
        .HDR_LEN(8'd7)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_en     (cfg_en),
        .cfg_hdr_len(cfg_hdr_len),
        .i_valid    (i_valid),
        .i_last     (i_last),
        .i_data     (i_data),
        .o_valid    (o_valid),
        .o_last     (o_last),
        .o_data     (o_data)
`ifdef SCR_STATS_EN
        ,
        .o_frame_cnt  (o_frame_cnt),
        .o_short_frame(o_short_frame)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int            checks = 0;
    int            errors = 0;
    bit            ks [0:2047];
    bit            in_frame;
    int            pos;
    int            frame_h;
    int            hdr_cur;
    int            exp_fcnt;
    logic [DW-1:0] last_obs;
    logic [DW-1:0] pat [0:15];
    logic [DW-1:0] cap [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] ks_beat(input int q);
        logic [DW-1:0] r;
        for (int i = 0; i < DW; i++) r[i] = ks[q*DW + i];
        return r;
    endfunction

    // One clock of stimulus; the output of this beat is checked 1 clk later.
    task automatic beat(input logic v, input logic l, input logic [DW-1:0] d);
        logic [DW-1:0] e;
        logic          short_e;
        i_valid = v;
        i_last  = l;
        i_data  = d;
        e       = d;
        short_e = 1'b0;
        if (v) begin
            if (!in_frame) begin
                in_frame = 1'b1;
                pos      = 0;
                frame_h  = hdr_cur;
            end
            if (pos >= frame_h && cfg_en) e = d ^ ks_beat(pos - frame_h);
            if (l) begin
                short_e  = (pos + 1 < frame_h);
                exp_fcnt = (exp_fcnt + 1) % 65536;
                in_frame = 1'b0;
            end
            pos++;
        end else begin
            in_frame = 1'b0;
        end
        @(posedge clk);
        #1;
        chk("o_valid", {31'd0, o_valid}, {31'd0, v});
        chk("o_last", {31'd0, o_last}, {31'd0, v & l});
        if (v) chk($sformatf("o_data pos%0d", pos - 1), {28'd0, o_data}, {28'd0, e});
        last_obs = o_data;
`ifdef SCR_STATS_EN
        chk("o_short_frame", {31'd0, o_short_frame}, {31'd0, short_e});
        chk("o_frame_cnt", {16'd0, o_frame_cnt}, exp_fcnt);
        if (o_short_frame) short_seen++;
`endif
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) beat(1'b0, 1'b0, DW'($urandom));
    endtask

    task automatic set_hdr(input int h);
        hdr_cur     = h;
        cfg_hdr_len = 8'(h);
        idle(1);
    endtask

    // Frame of zeros; returns the observed data of beat `probe`.
    task automatic zero_frame(input int n, input int probe, output logic [DW-1:0] seen);
        seen = '0;
        for (int p = 0; p < n; p++) begin
            beat(1'b1, p == n - 1, '0);
            if (p == probe) seen = last_obs;
        end
    endtask

    task automatic play_pat(input int n);
        for (int p = 0; p < n; p++) begin
            beat(1'b1, p == n - 1, pat[p]);
            cap.push_back(last_obs);
        end
    endtask

    initial begin : main
        logic [7:0]    l8;
        logic [DW-1:0] seen;
        int            len;
        bit            trunc;

        l8 = 8'hAA;
        for (int j = 0; j < 2048; j++) begin
            ks[j] = l8[7];
            l8    = {l8[6:0], ^(l8 & 8'h95)};
        end
        in_frame = 1'b0; pos = 0; frame_h = 7; hdr_cur = 7; exp_fcnt = 0;
`ifdef SCR_STATS_EN
        short_seen = 0;
`endif
        cfg_en = 1'b1; cfg_hdr_len = 8'd7;
        i_valid = 1'b0; i_last = 1'b0; i_data = '0;
        rst = 1'b1;
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst o_valid", {31'd0, o_valid}, 32'd0);
        chk("rst o_last", {31'd0, o_last}, 32'd0);
        chk("rst o_data", {28'd0, o_data}, 32'd0);
        #1 rst = 1'b1;

        // Zero frame with default 7-beat header: first payload beat carries keystream 1,0,1,0.
        zero_frame(12, 7, seen);
        chk("t1 first payload", {28'd0, seen}, 32'h5);
        idle(1);

        // Zero-length header, single beat.
        set_hdr(0);
        zero_frame(1, 0, seen);
        chk("t2 single beat", {28'd0, seen}, 32'h5);

        // Identical frames after a gap and back-to-back must give identical outputs.
        set_hdr(3);
        for (int i = 0; i < 16; i++) pat[i] = DW'($urandom);
        cap.delete();
        play_pat(10);
        idle(1);
        play_pat(10);
        play_pat(10);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("t3 gap b%0d", i), {28'd0, cap[10+i]}, {28'd0, cap[i]});
            chk($sformatf("t3 b2b b%0d", i), {28'd0, cap[20+i]}, {28'd0, cap[i]});
        end
        idle(1);

        // Bypass, then enable raised at payload beat 3.
        set_hdr(2);
        cfg_en = 1'b0;
        for (int p = 0; p < 8; p++) beat(1'b1, p == 7, DW'($urandom));
        for (int p = 0; p < 9; p++) begin
            cfg_en = (p >= 5);
            beat(1'b1, p == 8, DW'($urandom));
        end
        cfg_en = 1'b1;
        idle(1);

        // Header of 255 beats: exercises the counter at saturation.
        set_hdr(255);
        for (int p = 0; p < 259; p++) beat(1'b1, p == 258, DW'($urandom));
        idle(1);

        // Randomized frames, header lengths, enables, truncations and gaps.
        for (int f = 0; f < 30; f++) begin
            if ($urandom_range(0, 3) == 0) set_hdr($urandom_range(0, 9));
            len   = $urandom_range(1, 20);
            trunc = ($urandom_range(0, 5) == 0);
            for (int p = 0; p < len; p++) begin
                cfg_en = ($urandom_range(0, 3) != 0);
                beat(1'b1, (p == len - 1) && !trunc, DW'($urandom));
            end
            if (trunc) idle(1);
            idle($urandom_range(0, 2));
        end
        cfg_en = 1'b1;

        // Asynchronous reset in the middle of a payload.
        set_hdr(7);
        for (int p = 0; p < 10; p++) beat(1'b1, 1'b0, DW'($urandom));
        #3 rst = 1'b0;
        #1;
        chk("async rst o_valid", {31'd0, o_valid}, 32'd0);
        chk("async rst o_data", {28'd0, o_data}, 32'd0);
        i_valid = 1'b0; i_last = 1'b0;
        in_frame = 1'b0; exp_fcnt = 0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        #1;

`ifdef SCR_STATS_EN
        short_seen = 0;
        for (int p = 0; p < 3; p++) beat(1'b1, p == 2, DW'($urandom));
        idle(1);
        for (int p = 0; p < 10; p++) beat(1'b1, p == 9, DW'($urandom));
        idle(1);
        chk("t6 short pulses", short_seen, 32'd1);
        chk("t6 frame cnt", {16'd0, o_frame_cnt}, 32'd2);
`endif

        zero_frame(12, 7, seen);
        chk("t5 after reset", {28'd0, seen}, 32'h5);
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
